// File: rtl/arp_ctrl_if.sv
// ARP control bus: groups the arp_rx result, user trigger and arp_tx handshake
// signals of arp_ctrl into one bundle.
//   master : the controller side (arp_ctrl) - consumes rx/key/tx_done, drives tx/status
//   slave  : the environment side (arp_rx, arp_tx, user logic)
// Signals:
//   arp_rx_done  1-cycle pulse, pc_mac/pc_ip/arp_rx_op valid
//   arp_rx_op    received type: 0 = reply, 1 = request
//   pc_mac       sender MAC of received packet
//   pc_ip        sender IP of received packet
//   key_req      1-cycle pulse, user asks for an ARP request
//   arp_tx_done  1-cycle pulse, frame fully sent
//   arp_tx_en    1-cycle pulse, start one frame
//   arp_tx_op    frame type: 0 = reply, 1 = request
//   des_mac      target MAC for arp_tx
//   des_ip       target IP for arp_tx
//   peer_valid   a peer has been learned
//   busy         a frame is launching, in flight, or in its inter-frame gap
//   tx_timeout   1-cycle pulse when a frame aborts on timeout
interface arp_ctrl_if;
    logic        arp_rx_done;
    logic        arp_rx_op;
    logic [47:0] pc_mac;
    logic [31:0] pc_ip;
    logic        key_req;
    logic        arp_tx_done;
    logic        arp_tx_en;
    logic        arp_tx_op;
    logic [47:0] des_mac;
    logic [31:0] des_ip;
    logic        peer_valid;
    logic        busy;
    logic        tx_timeout;

    modport master (
        input  arp_rx_done,
        input  arp_rx_op,
        input  pc_mac,
        input  pc_ip,
        input  key_req,
        input  arp_tx_done,
        output arp_tx_en,
        output arp_tx_op,
        output des_mac,
        output des_ip,
        output peer_valid,
        output busy,
        output tx_timeout
    );

    modport slave (
        output arp_rx_done,
        output arp_rx_op,
        output pc_mac,
        output pc_ip,
        output key_req,
        output arp_tx_done,
        input  arp_tx_en,
        input  arp_tx_op,
        input  des_mac,
        input  des_ip,
        input  peer_valid,
        input  busy,
        input  tx_timeout
    );
endinterface

// File: rtl/arp_ctrl.sv
// ARP control stage between arp_rx and arp_tx.
// Caches the last received peer MAC/IP, schedules replies to received requests
// and requests from key_req or a periodic timer, and paces frames to arp_tx
// with a completion timeout and an inter-frame gap.
// Ports:
//   clk   single clock
//   rstn  synchronous active-low reset
//   bus   arp_ctrl_if.master (rx result, key_req, tx handshake, status)
module arp_ctrl #(
    parameter int unsigned REQ_PERIOD  = 0,
    parameter int unsigned TX_TIMEOUT  = 4096,
    parameter int unsigned IFG_CYCLES  = 12,
    parameter logic [47:0] DEF_DES_MAC = 48'hFFFF_FFFF_FFFF,
    parameter logic [31:0] DEF_DES_IP  = 32'hC0A8_0066
) (
    input  logic       clk,
    input  logic       rstn,
    arp_ctrl_if.master bus
);

    localparam int unsigned TO_W  = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;
    localparam int unsigned IFG_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam int unsigned PER_W = (REQ_PERIOD > 1) ? $clog2(REQ_PERIOD) : 1;

    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'((TX_TIMEOUT > 0) ? TX_TIMEOUT - 1 : 0);
    localparam logic [IFG_W-1:0] IFG_LAST = IFG_W'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'((REQ_PERIOD > 0) ? REQ_PERIOD - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_GAP    = 2'd3
    } state_e;

    state_e             state_q,      state_d;
    logic               tx_en_q,      tx_en_d;
    logic               op_q,         op_d;
    logic [47:0]        des_mac_q,    des_mac_d;
    logic [31:0]        des_ip_q,     des_ip_d;
    logic [47:0]        cache_mac_q,  cache_mac_d;
    logic [31:0]        cache_ip_q,   cache_ip_d;
    logic               peer_valid_q, peer_valid_d;
    logic               busy_q,       busy_d;
    logic               timeout_q,    timeout_d;
    logic               rep_pend_q,   rep_pend_d;
    logic               req_pend_q,   req_pend_d;
    logic [TO_W-1:0]    to_cnt_q,     to_cnt_d;
    logic [IFG_W-1:0]   gap_cnt_q,    gap_cnt_d;
    logic [PER_W-1:0]   per_cnt_q,    per_cnt_d;

    logic               per_tick_c;
    logic               rep_take_c;
    logic               req_take_c;
    logic               gap_last_c;

    // Next-state, counters, pending flags and registered outputs
    always_comb begin
        state_d      = state_q;
        tx_en_d      = 1'b0;
        op_d         = op_q;
        des_mac_d    = des_mac_q;
        des_ip_d     = des_ip_q;
        cache_mac_d  = cache_mac_q;
        cache_ip_d   = cache_ip_q;
        peer_valid_d = peer_valid_q;
        timeout_d    = 1'b0;
        to_cnt_d     = to_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        per_cnt_d    = per_cnt_q;
        per_tick_c   = 1'b0;
        rep_take_c   = 1'b0;
        req_take_c   = 1'b0;
        gap_last_c   = (IFG_CYCLES <= 1) || (gap_cnt_q == IFG_LAST);

        // Peer cache follows every received packet, whatever the FSM is doing
        if (bus.arp_rx_done) begin
            cache_mac_d  = bus.pc_mac;
            cache_ip_d   = bus.pc_ip;
            peer_valid_d = 1'b1;
        end

        // Free-running request timer, independent of the FSM
        if (REQ_PERIOD != 0) begin
            if (per_cnt_q == PER_LAST) begin
                per_tick_c = 1'b1;
                per_cnt_d  = '0;
            end else begin
                per_cnt_d  = per_cnt_q + PER_W'(1);
            end
        end

        unique case (state_q)
            S_IDLE: begin
                to_cnt_d  = '0;
                gap_cnt_d = '0;
                if (rep_pend_q) begin
                    rep_take_c = 1'b1;
                    op_d       = 1'b0;
                end else if (req_pend_q) begin
                    req_take_c = 1'b1;
                    op_d       = 1'b1;
                end
                // Target is loaded together with the launch pulse, from the
                // cache value including a packet arriving this very cycle
                if (rep_take_c || req_take_c) begin
                    state_d  = S_LAUNCH;
                    tx_en_d  = 1'b1;
                    des_ip_d = peer_valid_d ? cache_ip_d : DEF_DES_IP;
                    if (op_d) begin
                        des_mac_d = DEF_DES_MAC;
                    end else begin
                        des_mac_d = peer_valid_d ? cache_mac_d : DEF_DES_MAC;
                    end
                end
            end
            S_LAUNCH: begin
                // The launch cycle counts toward the timeout
                state_d  = S_WAIT;
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
            S_WAIT: begin
                if (bus.arp_tx_done) begin
                    state_d   = S_GAP;
                    gap_cnt_d = '0;
                end else if (to_cnt_q >= TO_LAST) begin
                    state_d   = S_GAP;
                    gap_cnt_d = '0;
                    timeout_d = 1'b1;
                end else begin
                    to_cnt_d  = to_cnt_q + TO_W'(1);
                end
            end
            S_GAP: begin
                if (gap_last_c) begin
                    state_d   = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + IFG_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Consume first, then set: a new event in the consuming cycle survives
        rep_pend_d = (rep_pend_q && !rep_take_c) || (bus.arp_rx_done && bus.arp_rx_op);
        req_pend_d = (req_pend_q && !req_take_c) || bus.key_req || per_tick_c;

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            tx_en_q      <= 1'b0;
            op_q         <= 1'b1;
            des_mac_q    <= DEF_DES_MAC;
            des_ip_q     <= DEF_DES_IP;
            cache_mac_q  <= '0;
            cache_ip_q   <= '0;
            peer_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
            rep_pend_q   <= 1'b0;
            req_pend_q   <= 1'b0;
            to_cnt_q     <= '0;
            gap_cnt_q    <= '0;
            per_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            tx_en_q      <= tx_en_d;
            op_q         <= op_d;
            des_mac_q    <= des_mac_d;
            des_ip_q     <= des_ip_d;
            cache_mac_q  <= cache_mac_d;
            cache_ip_q   <= cache_ip_d;
            peer_valid_q <= peer_valid_d;
            busy_q       <= busy_d;
            timeout_q    <= timeout_d;
            rep_pend_q   <= rep_pend_d;
            req_pend_q   <= req_pend_d;
            to_cnt_q     <= to_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            per_cnt_q    <= per_cnt_d;
        end
    end

    assign bus.arp_tx_en  = tx_en_q;
    assign bus.arp_tx_op  = op_q;
    assign bus.des_mac    = des_mac_q;
    assign bus.des_ip     = des_ip_q;
    assign bus.peer_valid = peer_valid_q;
    assign bus.busy       = busy_q;
    assign bus.tx_timeout = timeout_q;

endmodule
